// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: RAW and MDU stall generation for the five-stage pipeline with multicycle MDU sequencing
module pipe_hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Req,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_rs_tuse,
  input  logic [1:0] D_rt_tuse,
  input  logic       D_is_md,
  input  logic [4:0] E_A3,
  input  logic [4:0] M_A3,
  input  logic [1:0] E_tnew,
  input  logic [1:0] M_tnew,
  input  logic       E_md_start,
  input  logic       E_md_is_div,
  output logic       stall,
  output logic       mdu_busy,
  output logic       mdu_done,
  output logic [1:0] stall_cause
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC) + 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic rs_haz, rt_haz, md_haz;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (E_md_start && !Req) begin
        state <= BUSY;
        cnt   <= E_md_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end
    end else begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) state <= IDLE;
    end
  end
  assign mdu_busy = (state == BUSY);
  assign mdu_done = mdu_busy && (cnt == CW'(1));
  // tuse of 3 marks an unused operand and can never stall
  always_comb begin
    rs_haz = (D_rs != 5'd0) && (D_rs_tuse != 2'd3) &&
             ((D_rs == E_A3 && E_tnew > D_rs_tuse) || (D_rs == M_A3 && M_tnew > D_rs_tuse));
    rt_haz = (D_rt != 5'd0) && (D_rt_tuse != 2'd3) &&
             ((D_rt == E_A3 && E_tnew > D_rt_tuse) || (D_rt == M_A3 && M_tnew > D_rt_tuse));
    md_haz = D_is_md && (mdu_busy || E_md_start);
    stall = (rs_haz || rt_haz || md_haz) && !Req;
    stall_cause = !stall ? 2'd0 : rs_haz ? 2'd1 : rt_haz ? 2'd2 : 2'd3;
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed plan plus randomized traffic against a cycle-window reference model
module tb_pipe_hazard_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;
  logic clk = 0, reset, Req, D_is_md, E_md_start, E_md_is_div;
  logic [4:0] D_rs, D_rt, E_A3, M_A3;
  logic [1:0] D_rs_tuse, D_rt_tuse, E_tnew, M_tnew, stall_cause;
  logic stall, mdu_busy, mdu_done;
  int checks = 0, errors = 0;
  int cyc = 0;
  bit active = 0;
  int s_cyc = 0, n_len = 0;
  pipe_hazard_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .Req(Req), .D_rs(D_rs), .D_rt(D_rt),
    .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse), .D_is_md(D_is_md),
    .E_A3(E_A3), .M_A3(M_A3), .E_tnew(E_tnew), .M_tnew(M_tnew),
    .E_md_start(E_md_start), .E_md_is_div(E_md_is_div), .stall(stall),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done), .stall_cause(stall_cause)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic bit m_busy();
    return active && cyc > s_cyc && cyc <= s_cyc + n_len;
  endfunction
  function automatic bit haz(input int r, input int tu);
    int dst[2];
    int tn[2];
    dst[0] = E_A3; dst[1] = M_A3; tn[0] = E_tnew; tn[1] = M_tnew;
    if (r == 0 || tu == 3) return 0;
    for (int i = 0; i < 2; i++) if (dst[i] == r && tn[i] > tu) return 1;
    return 0;
  endfunction
  task automatic adv();
    bit rs, rt, md, st;
    @(negedge clk);
    rs = haz(D_rs, D_rs_tuse);
    rt = haz(D_rt, D_rt_tuse);
    md = D_is_md && (m_busy() || E_md_start);
    st = (rs || rt || md) && !Req;
    chk("m_stall", stall, st);
    chk("m_cause", stall_cause, !st ? 0 : rs ? 1 : rt ? 2 : 3);
    chk("m_busy", mdu_busy, m_busy());
    chk("m_done", mdu_done, m_busy() && cyc == s_cyc + n_len);
    @(posedge clk);
    if (reset) active = 0;
    else if (!m_busy() && E_md_start && !Req) begin
      active = 1; s_cyc = cyc; n_len = E_md_is_div ? DC : MC;
    end
    cyc++;
    #1;
  endtask
  task automatic quiet();
    reset = 0; Req = 0; D_is_md = 0; E_md_start = 0; E_md_is_div = 0;
    D_rs = 0; D_rt = 0; D_rs_tuse = 3; D_rt_tuse = 3;
    E_A3 = 0; M_A3 = 0; E_tnew = 0; M_tnew = 0;
  endtask
  initial begin
    int nb, nd;
    quiet();
    reset = 1;
    adv(); adv();
    reset = 0; #1;
    chk("rst_busy", mdu_busy, 0);
    chk("rst_done", mdu_done, 0);
    chk("rst_stall", stall, 0);
    E_A3 = 8; E_tnew = 2; D_rs = 8; D_rs_tuse = 1; #1;
    chk("raw_e_stall", stall, 1);
    chk("raw_e_cause", stall_cause, 1);
    adv();
    E_tnew = 1; #1;
    chk("raw_e_clear", stall, 0);
    adv();
    quiet(); E_A3 = 0; D_rs = 0; E_tnew = 2; D_rs_tuse = 0; #1;
    chk("reg_zero", stall, 0);
    quiet(); D_rt = 5; E_A3 = 5; E_tnew = 3; D_rt_tuse = 3; #1;
    chk("tuse_unused", stall, 0);
    quiet(); D_rt = 6; M_A3 = 6; M_tnew = 2; D_rt_tuse = 0; #1;
    chk("raw_m_rt_cause", stall_cause, 2);
    adv();
    quiet(); D_is_md = 1; E_md_start = 1;
    for (int k = 0; k <= 6; k++) begin
      #1;
      chk("mult_stall", stall, k <= 5);
      chk("mult_busy", mdu_busy, k >= 1 && k <= 5);
      chk("mult_done", mdu_done, k == 5);
      if (k <= 5) chk("mult_cause", stall_cause, 3);
      adv();
      E_md_start = 0;
    end
    quiet(); E_md_start = 1; E_md_is_div = 1; nb = 0; nd = 0;
    for (int k = 0; k < 14; k++) begin
      #1; nb += mdu_busy; nd += mdu_done;
      adv();
      E_md_start = 0;
    end
    chk("div_len", nb, DC);
    chk("div_done_cnt", nd, 1);
    quiet(); Req = 1; E_md_start = 1;
    adv();
    quiet(); #1;
    chk("req_cancel_start", mdu_busy, 0);
    D_is_md = 1; E_md_start = 1;
    for (int k = 0; k <= 6; k++) begin
      Req = (k == 3); #1;
      if (k == 3) chk("req_kills_stall", stall, 0);
      if (k == 5) chk("req_busy_last", mdu_busy, 1);
      if (k == 6) chk("req_busy_end", mdu_busy, 0);
      adv();
      E_md_start = 0;
    end
    quiet(); E_md_start = 1;
    for (int k = 0; k <= 3; k++) begin
      reset = (k == 2); #1;
      if (k == 3) begin
        chk("rst_mid_busy", mdu_busy, 0);
        chk("rst_mid_done", mdu_done, 0);
      end
      adv();
      E_md_start = 0;
    end
    quiet(); E_md_start = 1; nb = 0;
    for (int k = 0; k < 8; k++) begin
      #1; nb += mdu_busy;
      adv();
      E_md_start = 0;
    end
    chk("restart_len", nb, MC);
    for (int k = 0; k < 2000; k++) begin
      reset = ($urandom % 100) == 0;
      Req = ($urandom % 8) == 0;
      D_rs = 5'($urandom_range(0, 3)); D_rt = 5'($urandom_range(0, 3));
      E_A3 = 5'($urandom_range(0, 3)); M_A3 = 5'($urandom_range(0, 3));
      D_rs_tuse = 2'($urandom); D_rt_tuse = 2'($urandom);
      E_tnew = 2'($urandom); M_tnew = 2'($urandom);
      D_is_md = 1'($urandom);
      E_md_start = ($urandom % 6) == 0;
      E_md_is_div = 1'($urandom);
      adv();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and multicycle scheduler for the five-stage MIPS pipeline. It decides every cycle whether the F/D stages freeze and a bubble enters the E pipeline register. Stalls come from register read-after-write hazards (Tuse/Tnew comparison) and from the multiply/divide unit (MDU), whose multicycle busy window it sequences with an internal counter. It sits beside the pipeline registers and drives their shared `stall` input. `Req` (exception/interrupt) always overrides stall so the flush path wins.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration of mult/multu in cycles (>=1)
- DIV_CYCLES, 10, busy duration of div/divu in cycles (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- Req  in  1  exception/interrupt flush request this cycle
- D_rs, D_rt  in  5 each  source register numbers of the instruction in D
- D_rs_tuse, D_rt_tuse  in  2 each  cycles until the operand is needed; 3 = operand unused
- D_is_md  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- E_A3, M_A3  in  5 each  destination register in E / M (0 = none)
- E_tnew, M_tnew  in  2 each  cycles until the result is available from that stage
- E_md_start  in  1  E holds mult/multu/div/divu this cycle
- E_md_is_div  in  1  qualifies E_md_start: 1 = div class, 0 = mult class
- stall  out  1  freeze PC and D register, bubble E register
- mdu_busy  out  1  MDU operation in flight (registered)
- mdu_done  out  1  one-cycle pulse, last busy cycle
- stall_cause  out  2  0 none, 1 RAW on rs, 2 RAW on rt, 3 MDU

## Operation
- rs hazard: `D_rs != 0`, and either (`D_rs == E_A3` and `E_tnew > D_rs_tuse`) or (`D_rs == M_A3` and `M_tnew > D_rs_tuse`). A tuse of 3 never hazards. The rt hazard is identical using `D_rt` and `D_rt_tuse`.
- MDU hazard: `D_is_md` and (`mdu_busy` or `E_md_start`).
- `stall` = (rs hazard or rt hazard or MDU hazard) and not `Req`. Combinational.
- `stall_cause` priority: rs, then rt, then MDU. It is 0 whenever `stall` = 0.
- MDU FSM states: IDLE and BUSY, plus an internal counter `cnt` of width clog2(max(MULT_CYCLES, DIV_CYCLES)) + 1.
  - IDLE: when `E_md_start` = 1 and `Req` = 0 at a clock edge, load `cnt` with DIV_CYCLES or MULT_CYCLES (selected by `E_md_is_div`) and go to BUSY. Start with `Req` = 1 is cancelled and stays IDLE.
  - BUSY: `cnt` decrements every edge. At the edge where `cnt` = 1, go to IDLE with `cnt` = 0.
  - Req while BUSY does not abort: the operation completes and HI/LO commit.
  - E_md_start while BUSY cannot legally occur because the MDU hazard stalls it. If it does occur anyway, ignore it.
- `mdu_busy` = state is BUSY. `mdu_done` = BUSY and `cnt` = 1.

## Timing
- Reset (synchronous) puts the FSM in IDLE with `cnt` = 0, `mdu_busy` = 0 and `mdu_done` = 0. `stall` and `stall_cause` then depend only on the combinational inputs.
- Reset mid-operation drops `mdu_busy` at the next edge, and no `mdu_done` pulse is issued.
- `mdu_busy` rises the cycle after the accepted start edge and stays high for exactly N cycles, where N = MULT_CYCLES or DIV_CYCLES.
- `mdu_done` is high during the Nth busy cycle only.
- An md instruction in D is released in the first cycle `mdu_busy` is low. With E_md_start at cycle t, `stall` is high in cycles t .. t+N and low at t+N+1.
- `Req` forces `stall` = 0 in the same cycle, with no latency.
- Hazard stall has zero latency and holds while the condition holds. The pipeline advances the producer, so stalls self-clear.

## Test plan
- RAW on E: E_A3 = 8, E_tnew = 2, D_rs = 8, D_rs_tuse = 1 -> stall = 1, stall_cause = 1. Change E_tnew to 1 -> stall = 0.
- Register zero and unused operand: E_A3 = 0 with D_rs = 0 and E_tnew = 2 -> stall = 0. D_rt = E_A3 = 5 with D_rt_tuse = 3 -> stall = 0.
- Mult sequencing (MULT_CYCLES = 5): E_md_start = 1, E_md_is_div = 0 at cycle 0 -> mdu_busy high in cycles 1–5, mdu_done only in cycle 5. D_is_md = 1 throughout -> stall high in cycles 0–5, low in cycle 6, stall_cause = 3.
- Div length: E_md_start = 1, E_md_is_div = 1 -> mdu_busy high for exactly 10 cycles, with exactly one mdu_done pulse.
- Req interplay: Req = 1 with E_md_start = 1 -> mdu_busy stays 0. Req = 1 during cycle 3 of a busy window -> stall = 0 that cycle, and busy still ends after cycle 5.
- Reset mid-op: assert reset in busy cycle 2 -> mdu_busy = 0 and mdu_done = 0 the next cycle. A new start afterwards yields a full N-cycle window.
